// File: rtl/gate_sensor_ctrl.sv
`default_nettype none
// ============================================================================
// Module : gate_sensor_ctrl
// Brief  : Parking-gate front end. Synchronises and debounces the two beam
//          sensors and the hour button, decodes car direction into one-cycle
//          enter/exit/reject/seq_err pulses, and keeps the hour counter.
// Rev    : 1.0  initial release
// ============================================================================
module gate_sensor_ctrl #(
  parameter int DEBOUNCE  = 4,
  parameter int HOURS_MAX = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sens_a,
  input  logic       sens_b,
  input  logic       hour_btn,
  input  logic       full,
  output logic       enter,
  output logic       exit,
  output logic       reject,
  output logic       seq_err,
  output logic [2:0] hours,
  output logic       day_over
);

  localparam int                 c_CNT_W     = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(DEBOUNCE - 1);
  localparam logic [2:0]         c_HOURS_MAX = 3'(HOURS_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EN_A  = 3'd1,
    S_EN_AB = 3'd2,
    S_EN_B  = 3'd3,
    S_EX_B  = 3'd4,
    S_EX_AB = 3'd5,
    S_EX_A  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  // channel order: bit2 hour button, bit1 outer sensor a, bit0 inner sensor b
  logic [2:0] w_raw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_lvl_nxt;
  logic [1:0] w_ab;
  logic       r_btn_prev;
  logic       w_btn_rise;
  state_t     r_state;

  assign w_raw = {hour_btn, sens_a, sens_b};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // w_lvl_nxt is the level the debouncer will hold after this edge, so the
  // decoder reacts on the same edge the level is accepted.
  generate
    for (genvar i = 0; i < 3; i++) begin : g_deb
      logic               r_lvl;
      logic [c_CNT_W-1:0] r_cnt;
      logic               w_diff;

      assign w_diff       = r_sync2[i] ^ r_lvl;
      assign w_lvl_nxt[i] = (w_diff && (r_cnt == c_CNT_LAST)) ? r_sync2[i] : r_lvl;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_lvl <= 1'b0;
          r_cnt <= '0;
        end else if (!w_diff || (r_cnt == c_CNT_LAST)) begin
          r_lvl <= w_lvl_nxt[i];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  assign w_ab       = w_lvl_nxt[1:0];
  assign w_btn_rise = w_lvl_nxt[2] & ~r_btn_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      enter   <= 1'b0;
      exit    <= 1'b0;
      reject  <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      enter   <= 1'b0;
      exit    <= 1'b0;
      reject  <= 1'b0;
      seq_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ab == 2'b10)      r_state <= S_EN_A;
          else if (w_ab == 2'b01) r_state <= S_EX_B;
          else if (w_ab == 2'b11) begin r_state <= S_ERR; seq_err <= 1'b1; end
        end
        S_EN_A: begin
          if (w_ab == 2'b11)      r_state <= S_EN_AB;
          else if (w_ab == 2'b00) r_state <= S_IDLE;
          else if (w_ab == 2'b01) begin r_state <= S_ERR; seq_err <= 1'b1; end
        end
        S_EN_AB: begin
          if (w_ab == 2'b01)      r_state <= S_EN_B;
          else if (w_ab == 2'b10) r_state <= S_EN_A;
          else if (w_ab == 2'b00) begin r_state <= S_ERR; seq_err <= 1'b1; end
        end
        S_EN_B: begin
          if (w_ab == 2'b00) begin
            r_state <= S_IDLE;
            if (full) reject <= 1'b1;
            else      enter  <= 1'b1;
          end
          else if (w_ab == 2'b11) r_state <= S_EN_AB;
          else if (w_ab == 2'b10) begin r_state <= S_ERR; seq_err <= 1'b1; end
        end
        S_EX_B: begin
          if (w_ab == 2'b11)      r_state <= S_EX_AB;
          else if (w_ab == 2'b00) r_state <= S_IDLE;
          else if (w_ab == 2'b10) begin r_state <= S_ERR; seq_err <= 1'b1; end
        end
        S_EX_AB: begin
          if (w_ab == 2'b10)      r_state <= S_EX_A;
          else if (w_ab == 2'b01) r_state <= S_EX_B;
          else if (w_ab == 2'b00) begin r_state <= S_ERR; seq_err <= 1'b1; end
        end
        S_EX_A: begin
          if (w_ab == 2'b00)      begin r_state <= S_IDLE; exit <= 1'b1; end
          else if (w_ab == 2'b11) r_state <= S_EX_AB;
          else if (w_ab == 2'b01) begin r_state <= S_ERR; seq_err <= 1'b1; end
        end
        default: begin
          if (w_ab == 2'b00) r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_prev <= 1'b0;
      hours      <= 3'd0;
      day_over   <= 1'b0;
    end else begin
      r_btn_prev <= w_lvl_nxt[2];
      if (w_btn_rise) begin
        if (hours < c_HOURS_MAX) hours    <= hours + 3'd1;
        else                     day_over <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gate_sensor_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_gate_sensor_ctrl
// Brief  : Randomised gate sequences and hour-button presses against an
//          event-level reference model of gate_sensor_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gate_sensor_ctrl;

  localparam int D    = 4;
  localparam int HMAX = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sens_a = 1'b0;
  logic       sens_b = 1'b0;
  logic       hour_btn = 1'b0;
  logic       full = 1'b0;
  logic       enter, exit, reject, seq_err, day_over;
  logic [2:0] hours;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int multi_cnt = 0;
  int long_cnt  = 0;

  typedef struct { int kind; int cyc; } ev_t;  // kind: 0 enter 1 exit 2 reject 3 seq_err
  ev_t obs_q[$];

  gate_sensor_ctrl #(.DEBOUNCE(D), .HOURS_MAX(HMAX)) dut (
    .clk(clk), .reset(reset), .sens_a(sens_a), .sens_b(sens_b),
    .hour_btn(hour_btn), .full(full), .enter(enter), .exit(exit),
    .reject(reject), .seq_err(seq_err), .hours(hours), .day_over(day_over)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [3:0] prev_p = 4'd0;
  always @(negedge clk) begin : mon
    logic [3:0] p;
    p = {seq_err, reject, exit, enter};
    if (reset) begin
      for (int k = 0; k < 4; k++) if (p[k]) obs_q.push_back('{k, cyc});
      if ($countones(p) > 1) multi_cnt++;
      if ((p & prev_p) != 4'd0) long_cnt++;
    end
    prev_p = p;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive_ab(input logic [1:0] v);
    @(posedge clk); #1;
    sens_a = v[1];
    sens_b = v[0];
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Position of a code along a traversal: 0 empty, 1 first beam, 2 both, 3 last beam.
  function automatic int path_idx(input int dir, input logic [1:0] c);
    logic [1:0] e;
    e = (dir == 2) ? {c[0], c[1]} : c;
    case (e)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] path_code(input int dir, input int idx);
    logic [1:0] e;
    case (idx % 4)
      0:       e = 2'b00;
      1:       e = 2'b10;
      2:       e = 2'b11;
      default: e = 2'b01;
    endcase
    return (dir == 2) ? {e[0], e[1]} : e;
  endfunction

  // modes: 0 entry walk, 1 exit walk, 2 random codes, 3 back-out, 4 illegal jump
  task automatic run_trial(input int mode, input int f);
    logic [1:0] seq[$];
    ev_t        exp_q[$];
    logic [1:0] last, c;
    int         dir, pos, n, kind, t, p, lim;

    last = 2'b00;
    if (mode <= 1) begin
      p = 0;
      lim = 0;
      while (p < 4 && lim < 20) begin
        if (p > 1 && $urandom_range(0, 3) == 0) p--;
        else p++;
        seq.push_back(path_code(mode + 1, p));
        lim++;
      end
      if (p < 4) seq.push_back(2'b00);
    end else if (mode == 2) begin
      n = $urandom_range(2, 5);
      for (int i = 0; i < n; i++) begin
        do c = 2'($urandom_range(0, 3)); while (c == last);
        seq.push_back(c);
        last = c;
      end
      if (last != 2'b00) seq.push_back(2'b00);
    end else if (mode == 3) begin
      if ($urandom_range(0, 1) == 0) begin seq.push_back(2'b10); seq.push_back(2'b00); end
      else begin seq.push_back(2'b10); seq.push_back(2'b11); seq.push_back(2'b10); seq.push_back(2'b00); end
    end else begin
      seq.push_back(2'b11); seq.push_back(2'b01); seq.push_back(2'b00);
    end

    full = f[0];
    obs_q.delete();
    dir = 0;  // 0 idle, 1 entering, 2 exiting, 3 error
    pos = 0;
    last = 2'b00;
    foreach (seq[i]) begin
      c = seq[i];
      drive_ab(c);
      t = cyc;
      kind = -1;
      if (dir == 3) begin
        if (c == 2'b00) dir = 0;
      end else if (dir == 0) begin
        if (c == 2'b10)      begin dir = 1; pos = 1; end
        else if (c == 2'b01) begin dir = 2; pos = 1; end
        else if (c == 2'b11) begin dir = 3; kind = 3; end
      end else begin
        n = path_idx(dir, c);
        if (pos == 3 && n == 0) begin
          kind = (dir == 2) ? 1 : (f != 0 ? 2 : 0);
          dir = 0;
          pos = 0;
        end else if (n == pos + 1 || n == pos - 1) begin
          pos = n;
          if (pos == 0) dir = 0;
        end else begin
          dir = 3;
          kind = 3;
        end
      end
      if (kind >= 0) exp_q.push_back('{kind, t + 2 + D});
      wait_cyc(D + 3 + $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) begin
        drive_ab(c ^ (2'b01 << $urandom_range(0, 1)));
        wait_cyc(D - 2);
        drive_ab(c);
        wait_cyc(D + 3);
      end
      last = c;
    end
    wait_cyc(2 * D + 8);
    @(negedge clk);

    check_val("ev_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_val("ev_kind", obs_q[i].kind, exp_q[i].kind);
      check_val("ev_cycle", obs_q[i].cyc, exp_q[i].cyc);
    end
    full = 1'b0;
  endtask

  task automatic press(input int hold);
    @(posedge clk); #1 hour_btn = 1'b1;
    wait_cyc(hold);
    #1 hour_btn = 1'b0;
    wait_cyc(hold);
  endtask

  initial begin
    wait_cyc(3);
    @(negedge clk);
    check_val("rst_enter", enter, 0);
    check_val("rst_exit", exit, 0);
    check_val("rst_reject", reject, 0);
    check_val("rst_seq_err", seq_err, 0);
    check_val("rst_hours", hours, 0);
    check_val("rst_day_over", day_over, 0);
    @(posedge clk); #1 reset = 1'b1;
    wait_cyc(5);

    run_trial(0, 0);
    run_trial(1, 0);
    run_trial(0, 1);
    run_trial(1, 1);
    run_trial(3, 0);
    run_trial(4, 0);
    for (int t = 0; t < 40; t++) run_trial($urandom_range(0, 4), $urandom_range(0, 1));

    // abort an entry at its last step with reset; nothing may be reported
    obs_q.delete();
    drive_ab(2'b10); wait_cyc(D + 3);
    drive_ab(2'b11); wait_cyc(D + 3);
    drive_ab(2'b01); wait_cyc(D + 3);
    #3 reset = 1'b0; sens_a = 1'b0; sens_b = 1'b0;
    wait_cyc(3);
    #1 reset = 1'b1;
    wait_cyc(2 * D + 10);
    @(negedge clk);
    check_val("rst_abort_ev", obs_q.size(), 0);
    run_trial(0, 0);

    check_val("hours_start", hours, 0);
    for (int n = 1; n <= HMAX + 2; n++) begin
      press(10);
      @(negedge clk);
      check_val("hours_step", hours, (n < HMAX) ? n : HMAX);
      check_val("day_over", day_over, (n > HMAX) ? 1 : 0);
    end

    @(posedge clk); #1 hour_btn = 1'b1;
    wait_cyc(4);
    #3 reset = 1'b0;
    #1;
    check_val("async_rst_hours", hours, 0);
    check_val("async_rst_day", day_over, 0);
    hour_btn = 1'b0;
    wait_cyc(2);
    #1 reset = 1'b1;
    wait_cyc(20);
    @(negedge clk);
    check_val("post_rst_hours", hours, 0);
    press(10);
    @(negedge clk);
    check_val("post_rst_press", hours, 1);
    check_val("post_rst_day", day_over, 0);

    check_val("pulse_exclusive", multi_cnt, 0);
    check_val("pulse_one_cycle", long_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
